// File: rtl/rv32i_exec_sequencer.sv
// Multi-cycle control FSM for the RV32I R-type datapath: fetch over a valid/ready
// handshake, legality check, register read, ALU start/done, write-back and PC advance.
module rv32i_exec_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ALU_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic [6:0]  type_code,
  input  logic [9:0]  alu_op,
  output logic        rf_re,
  output logic        alu_start,
  input  logic        alu_done,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] pc,
  output logic [31:0] retire_cnt,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  // Fetch handshake: imem_req stays high from FETCH entry until the cycle
  // imem_ready is sampled high; that cycle transfers imem_rdata.
  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ALU_TIMEOUT - 1);
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t     state_q, state_d;
  logic [7:0] timer_q;
  logic       legal;
  logic       exec_first;

  assign legal      = (type_code == 7'b0110011) && (alu_op != 10'd0);
  assign exec_first = (state_q == S_EXEC) && (timer_q == 8'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        // alu_done in the start cycle belongs to no request of ours.
        if (!exec_first && alu_done) state_d = S_WB;
        else if (timer_q == TIMEOUT_LAST) state_d = S_TRAP;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 8'd0;
      pc         <= RESET_PC;
      instr      <= 32'd0;
      retire_cnt <= 32'd0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      imem_req   <= 1'b0;
      rf_we      <= 1'b0;
      retire     <= 1'b0;
    end else begin
      state_q  <= state_d;
      imem_req <= (state_d == S_FETCH);
      rf_we    <= (state_d == S_WB);
      retire   <= (state_d == S_WB);
      timer_q  <= (state_q == S_EXEC) ? timer_q + 8'd1 : 8'd0;
      if (state_q == S_FETCH && imem_ready) instr <= imem_rdata;
      if (state_q == S_WB) begin
        pc         <= pc + 32'd4;
        retire_cnt <= retire_cnt + 32'd1;
      end
      if (state_d == S_TRAP && state_q != S_TRAP) begin
        trap       <= 1'b1;
        trap_cause <= (state_q == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      end
    end
  end

  assign state     = state_q;
  assign rf_re     = (state_q == S_DECODE);
  assign alu_start = exec_first;
  assign imem_addr = (state_q == S_FETCH) ? pc : 32'd0;

endmodule

// File: tb/tb_rv32i_exec_sequencer.sv
// Directed bench for rv32i_exec_sequencer: cycle-by-cycle vectors with hand-computed
// expectations, a small R-type decoder model, and a RESET_PC wrap instance.
module tb_rv32i_exec_sequencer;

  localparam logic [31:0] ADD_W  = 32'h002081B3;
  localparam logic [31:0] SUB_W  = 32'h402081B3;
  localparam logic [31:0] ADDI_W = 32'h00100093;
  localparam logic [31:0] BAD_W  = 32'h402091B3;
  localparam logic [31:0] JUNK_W = 32'hDEADBEEF;

  logic        clk, rst, run;
  logic        imem_req, imem_ready, rf_re, alu_start, alu_done, rf_we, retire, trap;
  logic [31:0] imem_addr, imem_rdata, instr, pc, retire_cnt;
  logic [6:0]  type_code;
  logic [9:0]  alu_op;
  logic [1:0]  trap_cause;
  logic [2:0]  state;

  logic        d2_imem_req, d2_rf_re, d2_alu_start, d2_rf_we, d2_retire, d2_trap;
  logic [31:0] d2_imem_addr, d2_instr, d2_pc, d2_retire_cnt;
  logic [1:0]  d2_trap_cause;
  logic [2:0]  d2_state;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  int we_saved;

  rv32i_exec_sequencer #(.RESET_PC(32'h0000_0000), .ALU_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
    .type_code(type_code), .alu_op(alu_op), .rf_re(rf_re), .alu_start(alu_start),
    .alu_done(alu_done), .rf_we(rf_we), .retire(retire), .pc(pc),
    .retire_cnt(retire_cnt), .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  rv32i_exec_sequencer #(.RESET_PC(32'hFFFF_FFFC), .ALU_TIMEOUT(16)) dut_wrap (
    .clk(clk), .rst(rst), .run(run), .imem_req(d2_imem_req), .imem_addr(d2_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(d2_instr),
    .type_code(type_code), .alu_op(alu_op), .rf_re(d2_rf_re), .alu_start(d2_alu_start),
    .alu_done(alu_done), .rf_we(d2_rf_we), .retire(d2_retire), .pc(d2_pc),
    .retire_cnt(d2_retire_cnt), .trap(d2_trap), .trap_cause(d2_trap_cause), .state(d2_state)
  );

  // Decoder model: base ops one-hot by funct3, sub/sra on the upper bits.
  always_comb begin
    type_code = instr[6:0];
    alu_op    = 10'd0;
    if (instr[6:0] == 7'b0110011) begin
      case (instr[31:25])
        7'h00: alu_op = 10'd1 << instr[14:12];
        7'h20: begin
          if (instr[14:12] == 3'd0) alu_op = 10'h100;
          else if (instr[14:12] == 3'd5) alu_op = 10'h200;
        end
        default: alu_op = 10'd0;
      endcase
    end
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) we_cnt <= we_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; alu_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; alu_done = 1'b0;
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    check("rst_trap", {29'd0, trap, trap_cause}, 32'd0);
    check("rst_strobes", {27'd0, imem_req, rf_re, alu_start, rf_we, retire}, 32'd0);
    check("rst_wrap_pc", d2_pc, 32'hFFFF_FFFC);

    // add, back-to-back fetch, done one cycle after start
    rst = 1'b0; run = 1'b1; imem_ready = 1'b1; imem_rdata = ADD_W;
    tick();
    check("f1_state", 32'(state), 32'd1);
    check("f1_req", 32'(imem_req), 32'd1);
    check("f1_addr", imem_addr, 32'd0);
    tick();
    check("d1_state", 32'(state), 32'd2);
    check("d1_rf_re", 32'(rf_re), 32'd1);
    check("d1_instr", instr, ADD_W);
    check("d1_req", 32'(imem_req), 32'd0);
    tick();
    check("e1_start", 32'(alu_start), 32'd1);
    tick();
    alu_done = 1'b1;
    check("e1_start_once", 32'(alu_start), 32'd0);
    tick();
    alu_done = 1'b0;
    check("wb1_we_retire", {30'd0, rf_we, retire}, 32'd3);
    check("wb1_pc", pc, 32'd0);
    imem_ready = 1'b0; imem_rdata = JUNK_W;
    tick();
    check("f2_req", 32'(imem_req), 32'd1);
    check("f2_addr", imem_addr, 32'd4);
    check("f2_cnt", retire_cnt, 32'd1);
    check("f2_retire_off", 32'(retire), 32'd0);
    check("wrap_pc", d2_pc, 32'd0);

    // sub with ready delayed three cycles
    for (int i = 0; i < 3; i++) begin
      check("hold_req", 32'(imem_req), 32'd1);
      check("hold_addr", imem_addr, 32'd4);
      check("hold_instr", instr, ADD_W);
      tick();
    end
    check("hold_req4", 32'(imem_req), 32'd1);
    check("hold_addr4", imem_addr, 32'd4);
    imem_ready = 1'b1; imem_rdata = SUB_W;
    tick();
    check("d2_state", 32'(state), 32'd2);
    check("d2_instr", instr, SUB_W);
    imem_ready = 1'b0;
    tick();
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check("wb2_retire", 32'(retire), 32'd1);
    imem_ready = 1'b1; imem_rdata = ADD_W;
    tick();
    check("f3_pc", pc, 32'd8);
    check("f3_cnt", retire_cnt, 32'd2);

    // run dropped during EXEC: completes then parks
    tick();
    tick();
    run = 1'b0;
    check("e3_start", 32'(alu_start), 32'd1);
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check("wb3_retire", 32'(retire), 32'd1);
    tick();
    check("park_state", 32'(state), 32'd0);
    check("park_req", 32'(imem_req), 32'd0);
    check("park_pc", pc, 32'd12);
    check("park_cnt", retire_cnt, 32'd3);
    tick();
    check("park_state2", 32'(state), 32'd0);
    check("park_req2", 32'(imem_req), 32'd0);

    // ALU timeout; done in the start cycle is ignored
    run = 1'b1;
    tick();
    tick();
    tick();
    check("to_start", 32'(alu_start), 32'd1);
    alu_done = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      alu_done = 1'b0;
      check("to_wait", {28'd0, trap, state}, 32'd3);
    end
    tick();
    check("to_state", 32'(state), 32'd5);
    check("to_trap", 32'(trap), 32'd1);
    check("to_cause", 32'(trap_cause), 32'd2);
    check("to_pc", pc, 32'd12);
    check("to_cnt", retire_cnt, 32'd3);
    check("to_we_cnt", 32'(we_cnt), 32'd3);
    check("to_strobes", {27'd0, imem_req, rf_re, alu_start, rf_we, retire}, 32'd0);

    // illegal opcode traps and ignores run
    do_reset();
    check("ill_rst_pc", pc, 32'd0);
    check("ill_rst_trap", 32'(trap), 32'd0);
    we_saved = we_cnt;
    run = 1'b1; imem_ready = 1'b1; imem_rdata = ADDI_W;
    tick();
    tick();
    check("ill_rf_re", 32'(rf_re), 32'd1);
    tick();
    check("ill_state", 32'(state), 32'd5);
    check("ill_cause", {29'd0, trap, trap_cause}, 32'd5);
    check("ill_pc", pc, 32'd0);
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      tick();
      check("ill_frozen", {28'd0, imem_req, state}, 32'd5);
    end
    check("ill_instr", instr, ADDI_W);
    check("ill_no_we", 32'(we_cnt), 32'(we_saved));

    // R-type encoding with no ALU match
    do_reset();
    run = 1'b1; imem_ready = 1'b1; imem_rdata = BAD_W;
    tick();
    tick();
    tick();
    check("bad_cause", {29'd0, trap, trap_cause}, 32'd5);
    check("bad_pc", pc, 32'd0);

    // reset in the middle of a fetch
    do_reset();
    run = 1'b1; imem_ready = 1'b0;
    tick();
    check("mf_req", 32'(imem_req), 32'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("mf_req_drop", 32'(imem_req), 32'd0);
    check("mf_state", 32'(state), 32'd0);
    check("mf_pc", pc, 32'd0);
    check("mf_wrap_pc", d2_pc, 32'hFFFF_FFFC);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_sequencer.md
Name: rv32i_exec_sequencer

Overview:
Multi-cycle control FSM that drives the RV32I R-type decode/execute datapath. It fetches an instruction word over a valid/ready instruction-memory handshake, holds it for the combinational decoder, and checks the decoder's type_code/alu_op for legality. It then sequences register-file read, ALU start/done, and write-back, and advances the PC. It sits between instruction memory and the decoder/ALU/register file, and is the only block that issues fetches or register writes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ALU_TIMEOUT, 16, cycles allowed in EXEC without alu_done before trapping (range 1..255).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
run  input  1  level; 1 permits starting a new fetch.
imem_req  output  1  fetch request, held until imem_ready.
imem_addr  output  32  fetch address (= pc while imem_req=1, else 0).
imem_ready  input  1  fetch data valid this cycle.
imem_rdata  input  32  fetched instruction word.
instr  output  32  latched instruction to decoder.
type_code  input  7  decoder opcode field.
alu_op  input  10  decoder ALU op code; 0 = no match.
rf_re  output  1  register-file read enable (rs1/rs2).
alu_start  output  1  one-cycle ALU start pulse.
alu_done  input  1  ALU result valid.
rf_we  output  1  one-cycle write enable for rd.
retire  output  1  one-cycle pulse per completed instruction.
pc  output  32  current program counter.
retire_cnt  output  32  count of retired instructions.
trap  output  1  sticky fault flag.
trap_cause  output  2  01 illegal instruction, 10 ALU timeout, 00 none.
state  output  3  FSM state encoding, for debug.

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, instr=0, retire_cnt=0, trap=0, trap_cause=00. All strobes (imem_req, rf_re, alu_start, rf_we, retire) are 0. An in-flight fetch or ALU operation is abandoned; no write-back occurs.
- State encodings: IDLE=000, FETCH=001, DECODE=010, EXEC=011, WB=100, TRAP=101.
- IDLE: if run=1 -> FETCH next cycle; else stay.
- FETCH: imem_req=1, imem_addr=pc. When imem_ready=1 is sampled, latch instr<=imem_rdata and go to DECODE. Otherwise stay, holding the request. imem_ready outside FETCH is ignored.
- DECODE (1 cycle): rf_re=1. The instruction is legal iff type_code==7'b0110011 and alu_op!=0.
  - Legal -> EXEC.
  - Illegal -> TRAP with trap_cause=01; pc is not advanced.
- EXEC:
  - alu_start=1 only in the first EXEC cycle.
  - alu_done is sampled from the second EXEC cycle onward; alu_done in the start cycle is ignored.
  - An 8-bit timer clears on entry. If alu_done=1 -> WB. If ALU_TIMEOUT cycles elapse after the start cycle without done -> TRAP with trap_cause=10.
- WB (1 cycle): rf_we=1, retire=1, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), retire_cnt<=retire_cnt+1 (wraps).
  - Next state: FETCH if run=1, else IDLE.
  - run falling mid-instruction does not abort; the instruction completes and the FSM parks in IDLE.
- TRAP: trap=1 and all strobes 0. trap, trap_cause, pc, and instr are frozen. Only rst exits TRAP; run is ignored.
- instr holds its value until the next successful fetch.
- Minimum throughput: 5 cycles per instruction (FETCH with same-cycle ready, DECODE, 2 EXEC, WB).
- All outputs are registered, except imem_addr, alu_start, and rf_re, which may be decoded from state/pc.

Test Plan:
- Reset, run=1, imem_ready tied 1, imem_rdata=32'h002081B3 (add x3,x1,x2), alu_done one cycle after start -> imem_req at addr 0, rf_re, alu_start, rf_we+retire on cycle 5. Then pc=4, retire_cnt=1, fetch of addr 4 on the next cycle.
- imem_ready delayed 3 cycles, rdata=32'h402081B3 (sub) -> imem_req and imem_addr held steady for 4 cycles. instr latches only on the ready cycle; retires normally.
- imem_rdata=32'h00100093 (opcode 0010011) -> TRAP after DECODE. trap=1, trap_cause=01, pc unchanged, rf_we never asserted; run toggling has no effect until rst.
- rdata=32'h402091B3 (funct7=0100000, funct3=001, so decoder alu_op=0) -> trap_cause=01.
- alu_done held 0 with ALU_TIMEOUT=16 -> TRAP with trap_cause=10 exactly 16 cycles after the alu_start cycle. alu_done asserted only in the start cycle is ignored.
- Sequence boundaries:
  - RESET_PC=32'hFFFF_FFFC, one add retired -> pc=0.
  - run dropped during EXEC -> WB completes, then IDLE with no imem_req.
  - rst asserted mid-FETCH -> imem_req falls in the same cycle; pc=RESET_PC.
